ws2812_cmd: RTL
===============

Name: ws2812_cmd

Overview:
- Command/configuration front end for the LED controller.
- Accepts a byte stream from the SPI slave, qualified by a data/command select line.
- Sequences writes into the 64-word linked-list frame RAM (32-bit words: byte 3 holds the next address in bits [5:0], bytes 2..0 hold the 24-bit colour), programs the reset-code length, and issues the frame-start pulse to the WS2812 sequencer.
- Sits between the SPI slave and the sequencer's wr_* / rst_cnt inputs.

Parameters:
- CMD_CONF, 8'h2A, command: next 2 data bytes load rst_cnt_out (MSB first)
- CMD_ADDR, 8'h2B, command: next 1 data byte loads the RAM write address
- CMD_DATA, 8'h2C, command: subsequent data bytes stream into RAM
- CMD_SHOW, 8'h2D, command: pulse wr_done_out (start frame)
- RST_CNT_DEF, 16'd400, reset value of rst_cnt_out

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- byte_vld_in  input  1  one-cycle strobe; byte_data_in / dc_in valid
- byte_data_in  input  8  received SPI byte
- dc_in  input  1  0 = command byte, 1 = data byte
- wr_en_out  output  1  RAM write strobe
- wr_addr_out  output  6  RAM word address
- wr_data_out  output  8  write byte (sequencer replicates it across lanes)
- wr_byte_en_out  output  4  one-hot byte-lane enable
- wr_done_out  output  1  one-cycle frame-start pulse
- rst_cnt_out  output  16  reset-code length to sequencer

Behaviour:
- One clock (clk_in); reset is asynchronous and active-low (rst_n_in).
- Reset values:
  - state IDLE
  - wr_en_out 0, wr_addr_out 0, wr_data_out 0, wr_byte_en_out 4'b1000
  - wr_done_out 0
  - rst_cnt_out RST_CNT_DEF
  - internal MSB holding register 0
- Bytes are processed only when byte_vld_in = 1. Back-to-back strobes (every cycle) must be handled without loss.
- States: IDLE, CONF_H, CONF_L, ADDR, DATA.
- Command byte (dc_in = 0) is accepted in any state and aborts the current one:
  - CMD_CONF -> CONF_H
  - CMD_ADDR -> ADDR
  - CMD_DATA -> DATA
  - CMD_SHOW -> wr_done_out = 1 next cycle, state -> IDLE
  - any other code -> IDLE
  - Every command byte forces wr_byte_en_out to 4'b1000. wr_addr_out is unchanged, so a partially written word stays partial.
- Data byte (dc_in = 1), by state:
  - IDLE: ignored, no output change.
  - CONF_H: latch byte as MSB -> CONF_L.
  - CONF_L: rst_cnt_out <= {MSB, byte} next cycle -> IDLE. Further data bytes are ignored.
  - ADDR: wr_addr_out <= byte[5:0] (bits [7:6] ignored), wr_byte_en_out <= 4'b1000 -> IDLE.
  - DATA: next cycle wr_en_out = 1, with wr_data_out = byte and wr_addr_out / wr_byte_en_out equal to the lane being written. State remains DATA.
- Lane sequencing in DATA:
  - Lanes go 1000 -> 0100 -> 0010 -> 0001 (link byte first, then colour MSB to LSB).
  - After the 0001 write, wr_byte_en_out returns to 1000 and wr_addr_out increments by 1 on the following cycle.
  - Address wraps 63 -> 0.
- Write latency: exactly 1 cycle from byte_vld_in to wr_en_out. wr_en_out and wr_done_out are single-cycle pulses.
- wr_en_out is never asserted in the same cycle as wr_done_out.
- A data byte and its lane/address advance take effect together. The next byte, even if it arrives the very next cycle, uses the advanced lane/address.
- No backpressure. A CMD_SHOW during an ongoing frame is passed through unchanged; the sequencer ignores it when not idle.
- Reset mid-stream returns all outputs to their reset values immediately (asynchronously), including rst_cnt_out -> RST_CNT_DEF.

Test Plan:
- Reset, then no strobes -> rst_cnt_out = 400, wr_byte_en_out = 1000, wr_addr_out = 0, no wr_en_out/wr_done_out pulses.
- Cmd 2A, data 01, 2C -> rst_cnt_out = 16'h012C one cycle after the second data byte; a third data byte leaves it unchanged.
- Cmd 2B, data FF, then cmd 2C, data 05 AA BB CC back-to-back every cycle:
  - wr_addr_out = 63 after the address byte (bits [7:6] dropped).
  - Four write strobes, each with wr_addr_out = 63: (05, 1000), (AA, 0100), (BB, 0010), (CC, 0001).
  - wr_addr_out then wraps to 0 and wr_byte_en_out returns to 1000.
- Cmd 2C, data 01 02, then cmd 2D -> two writes at addr 0 with lanes 1000, 0100; wr_done_out pulses once; wr_byte_en_out back to 1000 with wr_addr_out still 0.
- Data bytes in IDLE, and unknown cmd 55 followed by data -> no wr_en_out, no register change.
- rst_n_in asserted after 2 of 4 bytes of a DATA word -> all outputs at reset values immediately; a following cmd 2C plus data writes at addr 0, lane 1000.

Source files
------------

// File: rtl/ws2812_cmd_if.sv
// Byte-stream input from the SPI slave and the frame-RAM write port to the sequencer.
interface ws2812_cmd_if;
   logic        byte_vld_in;
   logic [7:0]  byte_data_in;
   logic        dc_in;
   logic        wr_en_out;
   logic [5:0]  wr_addr_out;
   logic [7:0]  wr_data_out;
   logic [3:0]  wr_byte_en_out;
   logic        wr_done_out;
   logic [15:0] rst_cnt_out;

   // Command front end: consumes bytes, drives the RAM write port.
   modport slave (
      input  byte_vld_in, byte_data_in, dc_in,
      output wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out, wr_done_out, rst_cnt_out
   );

   // Byte source / write-port observer.
   modport master (
      output byte_vld_in, byte_data_in, dc_in,
      input  wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out, wr_done_out, rst_cnt_out
   );
endinterface

// File: rtl/ws2812_cmd.sv
// Command/configuration front end: decodes SPI bytes into frame-RAM writes,
// reset-code length updates and frame-start pulses.
module ws2812_cmd #(
   parameter logic [15:0] RST_CNT_DEF = 16'd400
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   ws2812_cmd_if.slave  bus
);

   localparam logic [7:0] CMD_CONF = 8'h2A;
   localparam logic [7:0] CMD_ADDR = 8'h2B;
   localparam logic [7:0] CMD_DATA = 8'h2C;
   localparam logic [7:0] CMD_SHOW = 8'h2D;
   localparam logic [3:0] LANE_LINK = 4'b1000;

   typedef enum logic [2:0] {StIdle, StConfH, StConfL, StAddr, StData} state_e;

   state_e      r_state, w_state_d;
   logic        r_wr_en, w_wr_en_d;
   logic [5:0]  r_wr_addr, w_wr_addr_d;
   logic [7:0]  r_wr_data, w_wr_data_d;
   logic [3:0]  r_wr_be, w_wr_be_d;
   logic        r_wr_done, w_wr_done_d;
   logic [15:0] r_rst_cnt, w_rst_cnt_d;
   logic [7:0]  r_msb, w_msb_d;
   // Write pointer: lane/address the next data byte will use.
   logic [5:0]  r_ptr_addr, w_ptr_addr_d;
   logic [3:0]  r_ptr_lane, w_ptr_lane_d;
   logic        w_write;

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state    <= StIdle;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_be    <= LANE_LINK;
         r_wr_done  <= 1'b0;
         r_rst_cnt  <= RST_CNT_DEF;
         r_msb      <= '0;
         r_ptr_addr <= '0;
         r_ptr_lane <= LANE_LINK;
      end else begin
         r_state    <= w_state_d;
         r_wr_en    <= w_wr_en_d;
         r_wr_addr  <= w_wr_addr_d;
         r_wr_data  <= w_wr_data_d;
         r_wr_be    <= w_wr_be_d;
         r_wr_done  <= w_wr_done_d;
         r_rst_cnt  <= w_rst_cnt_d;
         r_msb      <= w_msb_d;
         r_ptr_addr <= w_ptr_addr_d;
         r_ptr_lane <= w_ptr_lane_d;
      end
   end

   // Byte decode: next state, pointer advance and registered outputs.
   always_comb begin
      w_state_d    = r_state;
      w_wr_en_d    = 1'b0;
      w_wr_done_d  = 1'b0;
      w_wr_data_d  = r_wr_data;
      w_rst_cnt_d  = r_rst_cnt;
      w_msb_d      = r_msb;
      w_ptr_addr_d = r_ptr_addr;
      w_ptr_lane_d = r_ptr_lane;
      w_write      = 1'b0;

      if (bus.byte_vld_in) begin
         if (!bus.dc_in) begin
            // Any command aborts the current state; a partial word stays partial.
            w_ptr_lane_d = LANE_LINK;
            case (bus.byte_data_in)
               CMD_CONF: w_state_d = StConfH;
               CMD_ADDR: w_state_d = StAddr;
               CMD_DATA: w_state_d = StData;
               CMD_SHOW: begin
                  w_wr_done_d = 1'b1;
                  w_state_d   = StIdle;
               end
               default:  w_state_d = StIdle;
            endcase
         end else begin
            unique case (r_state)
               StConfH: begin
                  w_msb_d   = bus.byte_data_in;
                  w_state_d = StConfL;
               end
               StConfL: begin
                  w_rst_cnt_d = {r_msb, bus.byte_data_in};
                  w_state_d   = StIdle;
               end
               StAddr: begin
                  w_ptr_addr_d = bus.byte_data_in[5:0];
                  w_ptr_lane_d = LANE_LINK;
                  w_state_d    = StIdle;
               end
               StData: begin
                  w_write     = 1'b1;
                  w_wr_en_d   = 1'b1;
                  w_wr_data_d = bus.byte_data_in;
                  if (r_ptr_lane[0]) begin
                     w_ptr_lane_d = LANE_LINK;
                     w_ptr_addr_d = r_ptr_addr + 6'd1;
                  end else begin
                     w_ptr_lane_d = {1'b0, r_ptr_lane[3:1]};
                  end
               end
               default: ;
            endcase
         end
      end

      // A write shows the lane being written; otherwise show where the next byte goes.
      w_wr_addr_d = w_write ? r_ptr_addr : w_ptr_addr_d;
      w_wr_be_d   = w_write ? r_ptr_lane : w_ptr_lane_d;
   end

   assign bus.wr_en_out      = r_wr_en;
   assign bus.wr_addr_out    = r_wr_addr;
   assign bus.wr_data_out    = r_wr_data;
   assign bus.wr_byte_en_out = r_wr_be;
   assign bus.wr_done_out    = r_wr_done;
   assign bus.rst_cnt_out    = r_rst_cnt;

endmodule
